// File: rtl/mu0_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mu0_mem_responder
//  Description : Word-store memory responder for the MU0 datapath with a
//                req/ack handshake and programmable wait states.
//                Optional MU0_MEM_ERR_EN adds an out-of-range err output.
//  Revision    : 1.0  initial release
// ============================================================================
module mu0_mem_responder #(
    parameter int MAXWIDTH    = 16,
    parameter int ADDRWIDTH   = 12,
    parameter int DEPTH       = 4096,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rs,
    input  logic                 req,
    input  logic                 we,
    input  logic [ADDRWIDTH-1:0] addr,
    input  logic [MAXWIDTH-1:0]  wdata,
    output logic [MAXWIDTH-1:0]  rdata,
    output logic                 ack,
    output logic                 busy
`ifdef MU0_MEM_ERR_EN
    ,
    output logic                 err
`endif
);

    localparam int          c_IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  c_WAIT  = 4'(WAIT_CYCLES);
    localparam logic [31:0] c_DEPTH = 32'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [3:0]             r_cnt;
    logic [3:0]             w_cnt_next;
    logic                   r_we;
    logic [ADDRWIDTH-1:0]   r_addr;
    logic [MAXWIDTH-1:0]    r_wdata;
    logic [MAXWIDTH-1:0]    r_rdata;
    logic                   r_ack;
    logic                   w_enter_ack;
    logic                   w_we;
    logic [ADDRWIDTH-1:0]   w_addr;
    logic [MAXWIDTH-1:0]    w_wdata;
    logic [31:0]            w_addr_ext;
    logic                   w_in_range;
    logic [c_IDXW-1:0]      w_idx;
    logic [MAXWIDTH-1:0]    mem [DEPTH];

    always_comb begin
        w_next      = r_state;
        w_cnt_next  = r_cnt;
        w_enter_ack = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_cnt_next = c_WAIT;
                    if (c_WAIT == 4'd0) begin
                        w_next      = S_ACK;
                        w_enter_ack = 1'b1;
                    end else begin
                        w_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_next      = S_ACK;
                    w_enter_ack = 1'b1;
                end
            end
            S_ACK:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // With zero wait states the access happens on the request edge itself,
    // so the live request inputs are used instead of the latched copies.
    always_comb begin
        w_we       = (r_state == S_IDLE) ? we    : r_we;
        w_addr     = (r_state == S_IDLE) ? addr  : r_addr;
        w_wdata    = (r_state == S_IDLE) ? wdata : r_wdata;
        w_addr_ext = 32'(w_addr);
        w_in_range = (w_addr_ext < c_DEPTH);
        w_idx      = w_addr_ext[c_IDXW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rs) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_ack   <= (r_state == S_ACK);
            if (r_state == S_IDLE && req) begin
                r_we    <= we;
                r_addr  <= addr;
                r_wdata <= wdata;
            end
            if (w_enter_ack && !w_we)
                r_rdata <= w_in_range ? mem[w_idx] : '0;
        end
    end

    // Storage is never cleared by reset.
    always_ff @(posedge clk) begin
        if (!rs && w_enter_ack && w_we && w_in_range)
            mem[w_idx] <= w_wdata;
    end

`ifdef MU0_MEM_ERR_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (rs)
            r_err <= 1'b0;
        else
            r_err <= (r_state == S_ACK) && (32'(r_addr) >= c_DEPTH);
    end

    assign err = r_err;
`endif

    assign rdata = r_rdata;
    assign ack   = r_ack;
    assign busy  = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mu0_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mu0_mem_responder
//  Description : Scoreboard bench for mu0_mem_responder across three configs
//                (2 waits / 0 waits / DEPTH=256).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mu0_mem_responder;

    typedef struct {
        int          d;
        logic        w;
        logic [11:0] a;
        logic [15:0] wd;
        logic [15:0] exp;
        logic        oor;
    } txn_t;

    logic        clk = 1'b0;
    logic        rs  = 1'b1;
    logic        req   [3];
    logic        we    [3];
    logic [11:0] addr  [3];
    logic [15:0] wdata [3];
    logic [15:0] rdata [3];
    logic        ack   [3];
    logic        busy  [3];
`ifdef MU0_MEM_ERR_EN
    logic        err   [3];
`endif

    int   c_wait  [3] = '{2, 0, 2};
    int   c_depth [3] = '{4096, 4096, 256};
    logic [15:0] mdl [3][4096];
    txn_t sbq [$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mu0_mem_responder #(.MAXWIDTH(16), .ADDRWIDTH(12), .DEPTH(4096), .WAIT_CYCLES(2)) u_dut0 (
        .clk(clk), .rs(rs), .req(req[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
        .rdata(rdata[0]), .ack(ack[0]), .busy(busy[0])
`ifdef MU0_MEM_ERR_EN
        , .err(err[0])
`endif
    );

    mu0_mem_responder #(.MAXWIDTH(16), .ADDRWIDTH(12), .DEPTH(4096), .WAIT_CYCLES(0)) u_dut1 (
        .clk(clk), .rs(rs), .req(req[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
        .rdata(rdata[1]), .ack(ack[1]), .busy(busy[1])
`ifdef MU0_MEM_ERR_EN
        , .err(err[1])
`endif
    );

    mu0_mem_responder #(.MAXWIDTH(16), .ADDRWIDTH(12), .DEPTH(256), .WAIT_CYCLES(2)) u_dut2 (
        .clk(clk), .rs(rs), .req(req[2]), .we(we[2]), .addr(addr[2]), .wdata(wdata[2]),
        .rdata(rdata[2]), .ack(ack[2]), .busy(busy[2])
`ifdef MU0_MEM_ERR_EN
        , .err(err[2])
`endif
    );

    // Issue one request on instance d and score its completion; caller is at a negedge.
    task automatic do_txn(input int d, input logic w, input logic [11:0] a,
                          input logic [15:0] wd, input logic hold, input logic perturb);
        txn_t t;
        int   lat;
        logic got;
        t.d   = d;
        t.w   = w;
        t.a   = a;
        t.wd  = wd;
        t.oor = (int'(a) >= c_depth[d]);
        t.exp = (w || t.oor) ? 16'h0000 : mdl[d][a];
        sbq.push_back(t);
        req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                checks++;
                if (busy[d] !== 1'b1) begin
                    failures++;
                    $display("FAIL busy_in_txn d=%0d a=%h actual=%b required=1", d, a, busy[d]);
                end
                if (perturb) begin
                    addr[d]  = a ^ 12'h001;
                    wdata[d] = ~wd;
                end
            end
            if (ack[d] === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL ack_timeout d=%0d a=%h actual=no_ack required=ack", d, a);
            if (sbq.size() > 0) void'(sbq.pop_front());
        end else begin
            t = sbq.pop_front();
            if (lat != c_wait[d] + 2) begin
                failures++;
                $display("FAIL ack_latency d=%0d a=%h actual=%0d required=%0d", d, a, lat, c_wait[d] + 2);
            end
            checks++;
            if (busy[d] !== 1'b0) begin
                failures++;
                $display("FAIL busy_at_ack d=%0d actual=%b required=0", d, busy[d]);
            end
            if (!t.w) begin
                checks++;
                if (rdata[d] !== t.exp) begin
                    failures++;
                    $display("FAIL read_data d=%0d a=%h actual=%h required=%h", d, t.a, rdata[d], t.exp);
                end
            end else if (!t.oor) begin
                mdl[d][t.a] = t.wd;
            end
`ifdef MU0_MEM_ERR_EN
            checks++;
            if (err[d] !== t.oor) begin
                failures++;
                $display("FAIL err_flag d=%0d a=%h actual=%b required=%b", d, t.a, err[d], t.oor);
            end
`endif
        end
        if (!hold) req[d] = 1'b0;
    endtask

    task automatic test_reset();
        rs = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rs = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (ack[d] !== 1'b0) begin
                failures++;
                $display("FAIL reset_ack d=%0d actual=%b required=0", d, ack[d]);
            end
            checks++;
            if (busy[d] !== 1'b0) begin
                failures++;
                $display("FAIL reset_busy d=%0d actual=%b required=0", d, busy[d]);
            end
            checks++;
            if (rdata[d] !== 16'h0000) begin
                failures++;
                $display("FAIL reset_rdata d=%0d actual=%h required=0000", d, rdata[d]);
            end
        end
    endtask

    task automatic test_write_read();
        do_txn(0, 1'b1, 12'h010, 16'hBEEF, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (ack[0] !== 1'b0) begin
            failures++;
            $display("FAIL ack_one_cycle actual=%b required=0", ack[0]);
        end
        do_txn(0, 1'b0, 12'h010, 16'h0000, 1'b0, 1'b0);
        do_txn(0, 1'b1, 12'hFFF, 16'h0F1E, 1'b0, 1'b0);
        do_txn(0, 1'b0, 12'hFFF, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        do_txn(1, 1'b1, 12'h040, 16'h1111, 1'b1, 1'b0);
        do_txn(1, 1'b0, 12'h040, 16'h0000, 1'b1, 1'b0);
        do_txn(1, 1'b1, 12'h040, 16'h2222, 1'b1, 1'b0);
        do_txn(1, 1'b0, 12'h040, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_abort();
        do_txn(0, 1'b1, 12'h020, 16'hAAAA, 1'b0, 1'b0);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            req[0] = 1'b1; we[0] = (k == 0); addr[0] = 12'h020; wdata[0] = 16'h5555;
            @(negedge clk);
            rs = 1'b1;
            req[0] = 1'b0;
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                rs = 1'b0;
                checks++;
                if (ack[0] !== 1'b0 || busy[0] !== 1'b0) begin
                    failures++;
                    $display("FAIL abort_quiet k=%0d c=%0d actual=ack%b_busy%b required=ack0_busy0",
                             k, c, ack[0], busy[0]);
                end
            end
            checks++;
            if (rdata[0] !== 16'h0000) begin
                failures++;
                $display("FAIL abort_rdata k=%0d actual=%h required=0000", k, rdata[0]);
            end
        end
        do_txn(0, 1'b0, 12'h020, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_out_of_range();
        do_txn(2, 1'b1, 12'h0FF, 16'h00FF, 1'b0, 1'b0);
        do_txn(2, 1'b1, 12'h100, 16'h1234, 1'b0, 1'b0);
        do_txn(2, 1'b0, 12'h100, 16'h0000, 1'b0, 1'b0);
        do_txn(2, 1'b0, 12'h0FF, 16'h0000, 1'b0, 1'b0);
        do_txn(2, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_latched_inputs();
        do_txn(0, 1'b1, 12'h031, 16'h0F0F, 1'b0, 1'b0);
        do_txn(0, 1'b1, 12'h030, 16'h5555, 1'b0, 1'b1);
        do_txn(0, 1'b0, 12'h031, 16'h0000, 1'b0, 1'b0);
        do_txn(0, 1'b0, 12'h030, 16'h0000, 1'b0, 1'b1);
        @(negedge clk);
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            req[d] = 1'b0; we[d] = 1'b0; addr[d] = 12'h000; wdata[d] = 16'h0000;
        end
        mdl[2][12'h000] = 16'h0000;
        test_reset();
        // Seed location 0 of the small instance so reading it has a known value.
        do_txn(2, 1'b1, 12'h000, 16'h0000, 1'b0, 1'b0);
        test_write_read();
        test_back_to_back();
        test_abort();
        test_out_of_range();
        test_latched_inputs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
